// File: rtl/snitch_lsu_rob.sv
// snitch_lsu_rob -- reorder buffer for in-flight loads.
//
// Requests allocate a slot (meta ID) in allocation order. Memory responses
// may come back in any order, each tagged with its meta ID. Completed
// entries retire strictly in allocation order from the head of the ring.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_valid_i / req_ready_o    slot allocation handshake
//   req_id_o                     meta ID granted on the allocation handshake
//   resp_valid_i, resp_id_i,
//   resp_data_i, resp_error_i    memory response (no backpressure)
//   out_valid_o / out_ready_i    in-order retirement handshake
//   out_data_o, out_error_o      contents of the retiring (head) entry
//   count_o                      number of slots currently allocated
//   spurious_o                   one-cycle pulse, one cycle after a response
//                                hitting a free or already-completed slot
module snitch_lsu_rob #(
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned NumOutstanding = 8,
   localparam int unsigned IdWidth       = $clog2(NumOutstanding)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   output logic [IdWidth-1:0]   req_id_o,
   input  logic                 resp_valid_i,
   input  logic [IdWidth-1:0]   resp_id_i,
   input  logic [DataWidth-1:0] resp_data_i,
   input  logic                 resp_error_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [DataWidth-1:0] out_data_o,
   output logic                 out_error_o,
   output logic [IdWidth:0]     count_o,
   output logic                 spurious_o
);

   // Pointers wrap by natural overflow, which is only correct for a
   // power-of-two depth.
   if (NumOutstanding < 2 || (NumOutstanding & (NumOutstanding - 1)) != 0) begin : g_bad_depth
      $error("snitch_lsu_rob: NumOutstanding must be a power of two >= 2");
   end

   localparam logic [IdWidth:0] Depth = (IdWidth+1)'(NumOutstanding);

   logic [NumOutstanding-1:0][DataWidth-1:0] data_q;
   logic [NumOutstanding-1:0]                err_q;
   logic [NumOutstanding-1:0]                alloc_q;
   logic [NumOutstanding-1:0]                done_q;
   logic [IdWidth-1:0]                       head_q, tail_q;
   logic [IdWidth:0]                         count_q;
   logic                                     spurious_q;

   logic push, pop, resp_hit;

   // Ready depends only on the registered count: a slot freed by a retire
   // becomes allocatable one cycle later.
   assign req_ready_o = (count_q < Depth);
   assign req_id_o    = tail_q;
   assign out_valid_o = alloc_q[head_q] & done_q[head_q];
   assign out_data_o  = data_q[head_q];
   assign out_error_o = err_q[head_q];
   assign count_o     = count_q;
   assign spurious_o  = spurious_q;

   assign push = req_valid_i & req_ready_o;
   assign pop  = out_valid_o & out_ready_i;
   // Uses the pre-edge alloc bit, so a response to the slot being allocated
   // in the same cycle is spurious.
   assign resp_hit = resp_valid_i & alloc_q[resp_id_i] & ~done_q[resp_id_i];

   // push (tail, alloc=0), resp_hit (alloc=1, done=0) and pop (done=1)
   // always target distinct slots, so their updates never collide.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         alloc_q    <= '0;
         done_q     <= '0;
         spurious_q <= 1'b0;
      end else begin
         spurious_q <= resp_valid_i & ~resp_hit;
         if (push) begin
            alloc_q[tail_q] <= 1'b1;
            done_q[tail_q]  <= 1'b0;
            tail_q          <= tail_q + 1'b1;
         end
         if (resp_hit) begin
            done_q[resp_id_i] <= 1'b1;
         end
         if (pop) begin
            alloc_q[head_q] <= 1'b0;
            done_q[head_q]  <= 1'b0;
            head_q          <= head_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Payload storage needs no reset; it is only observed once done is set.
   always_ff @(posedge clk_i) begin
      if (!rst_i && resp_hit) begin
         data_q[resp_id_i] <= resp_data_i;
         err_q[resp_id_i]  <= resp_error_i;
      end
   end

endmodule
